sof_phase_scanner: RTL and testbench

- Controller for the trigger-link oversampler when built with manual phase selection.
- Sequences all 8 sample settings (4 phase taps × polarity swap) and counts synchronized phase errors per setting over a fixed dwell window.
- Applies the cleanest setting, then monitors the locked link and rescans automatically on sustained error.
- One instance per trigger-link oversampler; sits in the trigger alignment block and drives its phase_sel_in/polswap_in.

---
 rtl/trig_align_pkg.sv | 20 ++
 rtl/err_window_counter.sv | 43 ++++
 rtl/sof_phase_scanner.sv | 167 ++++++++++++++++
 tb/tb_sof_phase_scanner.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_align_pkg.sv
// trig_align_pkg: shared definitions for the trigger alignment block.
// Provides the phase-scanner state encoding, the field layout of the 3-bit
// setting index {polswap, phase_sel} and the number of oversampler settings.
package trig_align_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        SETTLE,
        MEASURE,
        APPLY,
        LOCKED
    } scan_state_e;

    localparam int PHASE_LSB    = 0;
    localparam int PHASE_W      = 2;
    localparam int POLSWAP_BIT  = 2;
    localparam int NUM_SETTINGS = 8;

endpackage

// File: rtl/err_window_counter.sv
// err_window_counter: fixed-length window counter with a saturating error count.
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset
//   en_i         : count while high; low clears window position and error count
//   err_i        : error strobe sampled every enabled cycle
//   done_o       : high on the last cycle of each DWELL_CYCLES-long window
//   count_o      : error count including the current cycle (final count when done_o)
module err_window_counter #(
    parameter int DWELL_CYCLES = 1024,
    parameter int CW           = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          err_i,
    output logic          done_o,
    output logic [CW-1:0] count_o
);

    localparam int WW = $clog2(DWELL_CYCLES + 1);

    logic [WW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        count_o = (err_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        done_o  = en_i && win_q == WW'(DWELL_CYCLES - 1);
        // The window restarts by itself after each boundary.
        win_d   = (!en_i || done_o) ? '0 : win_q + 1'b1;
        cnt_d   = (!en_i || done_o) ? '0 : count_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q <= '0;
            cnt_q <= '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sof_phase_scanner.sv
// sof_phase_scanner: phase/polarity scan and lock controller for the trigger-link oversampler.
// Scans all 8 settings {polswap, phase_sel}, counts phase errors per setting over a
// dwell window, applies the cleanest one and monitors it, rescanning on lost lock.
// Ports:
//   clock, reset : 40 MHz logic clock, synchronous active-high reset
//   enable       : run the scanner; low forces IDLE
//   rescan       : single-cycle restart request (ignored in IDLE)
//   phase_err    : synchronized oversampler phase error
//   phase_sel, polswap : applied setting, to the oversampler
//   locked, scanning   : status
//   best_setting, best_errcnt : chosen setting and its error count
//   relock_cnt   : saturating count of lock-lost events
//   err_hist     : per-setting last MEASURE count (only with SOF_PHASE_SCANNER_HISTORY_EN)
module sof_phase_scanner
    import trig_align_pkg::*;
#(
    parameter int DWELL_CYCLES  = 1024,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_MAX_ERR  = 4,
    parameter int LOST_THRESH   = 16,
    parameter int CW            = 11
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          rescan,
    input  logic          phase_err,
    output logic [1:0]    phase_sel,
    output logic          polswap,
    output logic          locked,
    output logic          scanning,
    output logic [2:0]    best_setting,
    output logic [CW-1:0] best_errcnt,
    output logic [7:0]    relock_cnt
`ifdef SOF_PHASE_SCANNER_HISTORY_EN
    ,
    output logic [8*CW-1:0] err_hist
`endif
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    scan_state_e   state_q;
    logic [2:0]    idx_q;
    logic [2:0]    best_set_q;
    logic [CW-1:0] best_err_q;
    logic [SW-1:0] sc_q;
    logic          locked_q;
    logic          scanning_q;
    logic [7:0]    relock_q;
    logic          win_done;
    logic [CW-1:0] win_cnt;

    err_window_counter #(
        .DWELL_CYCLES(DWELL_CYCLES),
        .CW          (CW)
    ) u_win (
        .clk_i  (clock),
        .rst_i  (reset),
        .en_i   (state_q == MEASURE || state_q == LOCKED),
        .err_i  (phase_err),
        .done_o (win_done),
        .count_o(win_cnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            best_set_q <= '0;
            best_err_q <= '0;
            sc_q       <= '0;
            locked_q   <= 1'b0;
            scanning_q <= 1'b0;
            relock_q   <= '0;
        end else if (!enable) begin
            state_q    <= IDLE;
            sc_q       <= '0;
            locked_q   <= 1'b0;
            scanning_q <= 1'b0;
        end else if (rescan && state_q != IDLE) begin
            state_q    <= SET;
            sc_q       <= '0;
            locked_q   <= 1'b0;
            scanning_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= SET;
                    scanning_q <= 1'b1;
                end
                SET: begin
                    idx_q      <= '0;
                    best_err_q <= '1;
                    best_set_q <= '0;
                    state_q    <= SETTLE;
                end
                SETTLE: begin
                    sc_q    <= (sc_q == SW'(SETTLE_CYCLES - 1)) ? '0 : sc_q + 1'b1;
                    state_q <= (sc_q == SW'(SETTLE_CYCLES - 1)) ? MEASURE : SETTLE;
                end
                MEASURE: begin
                    if (win_done) begin
                        // Strict compare: on a tie the lower index already stored wins.
                        if (win_cnt < best_err_q) begin
                            best_err_q <= win_cnt;
                            best_set_q <= idx_q;
                        end
                        if (idx_q == 3'(NUM_SETTINGS - 1)) begin
                            state_q    <= APPLY;
                            scanning_q <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= SETTLE;
                        end
                    end
                end
                APPLY: begin
                    // APPLY also holds the post-apply pipeline flush (sc 0..SETTLE_CYCLES).
                    idx_q <= best_set_q;
                    if (best_err_q > CW'(LOCK_MAX_ERR)) begin
                        state_q    <= SET;
                        scanning_q <= 1'b1;
                        sc_q       <= '0;
                    end else if (sc_q == SW'(SETTLE_CYCLES)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        sc_q     <= '0;
                    end else begin
                        sc_q <= sc_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (win_done && win_cnt > CW'(LOST_THRESH)) begin
                        state_q    <= SET;
                        locked_q   <= 1'b0;
                        scanning_q <= 1'b1;
                        relock_q   <= relock_q + {7'd0, relock_q != 8'hFF};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SOF_PHASE_SCANNER_HISTORY_EN
    logic [8*CW-1:0] hist_q;

    always_ff @(posedge clock) begin
        if (reset)
            hist_q <= '0;
        else if (enable && !rescan && state_q == MEASURE && win_done)
            hist_q[idx_q*CW +: CW] <= win_cnt;
    end

    assign err_hist = hist_q;
`endif

    assign phase_sel    = idx_q[PHASE_LSB +: PHASE_W];
    assign polswap      = idx_q[POLSWAP_BIT];
    assign locked       = locked_q;
    assign scanning     = scanning_q;
    assign best_setting = best_set_q;
    assign best_errcnt  = best_err_q;
    assign relock_cnt   = relock_q;

endmodule

// File: tb/tb_sof_phase_scanner.sv
// tb_sof_phase_scanner: self-checking bench with a scan-timeline reference model.
module tb_sof_phase_scanner;

    localparam int D      = 1024;
    localparam int S      = 8;
    localparam int LME    = 4;
    localparam int LT     = 16;
    localparam int CW     = 11;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int L      = S + D;
    localparam int APPLY0 = 8 * L + 1;
    localparam int LOCK0  = APPLY0 + S + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          rescan = 1'b0;
    logic          phase_err = 1'b0;
    logic [1:0]    phase_sel;
    logic          polswap;
    logic          locked;
    logic          scanning;
    logic [2:0]    best_setting;
    logic [CW-1:0] best_errcnt;
    logic [7:0]    relock_cnt;
`ifdef SOF_PHASE_SCANNER_HISTORY_EN
    logic [8*CW-1:0] err_hist;
`endif

    int checks = 0;
    int failures = 0;

    sof_phase_scanner #(
        .DWELL_CYCLES (D),
        .SETTLE_CYCLES(S),
        .LOCK_MAX_ERR (LME),
        .LOST_THRESH  (LT),
        .CW           (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .rescan      (rescan),
        .phase_err   (phase_err),
        .phase_sel   (phase_sel),
        .polswap     (polswap),
        .locked      (locked),
        .scanning    (scanning),
        .best_setting(best_setting),
        .best_errcnt (best_errcnt),
        .relock_cnt  (relock_cnt)
`ifdef SOF_PHASE_SCANNER_HISTORY_EN
        ,
        .err_hist    (err_hist)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: position m_pos along the scan timeline
    // (0 = SET, 1..8L = settle/measure per setting, APPLY0.. = apply+flush, LOCK0.. = locked).
    int m_mode, m_pos, m_acc, m_idx, m_best_err, m_best_set, m_relock, m_nvalid;
    int m_errs[8];
    int m_hist[8];
    bit m_exp_locked, m_exp_scanning;
    int pe_mode = 0;
    int inj = 0;

    task automatic check(string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(int v);
        return v > CMAX ? CMAX : v;
    endfunction

    task automatic model_step();
        int k, r;
        if (reset) begin
            m_mode = 0; m_pos = 0; m_acc = 0; m_idx = 0;
            m_best_err = 0; m_best_set = 0; m_relock = 0; m_nvalid = 0;
            foreach (m_hist[i]) m_hist[i] = 0;
        end else if (!enable) begin
            m_mode = 0; m_acc = 0;
        end else if (m_mode == 0 || rescan) begin
            m_mode = 1; m_pos = 0; m_acc = 0;
        end else if (m_pos == 0) begin
            m_idx = 0; m_best_err = CMAX; m_best_set = 0; m_nvalid = 0; m_pos = 1;
        end else if (m_pos <= 8 * L) begin
            k = (m_pos - 1) / L;
            r = (m_pos - 1) % L;
            if (r >= S) m_acc = sat(m_acc + int'(phase_err));
            if (r == L - 1) begin
                m_errs[k] = m_acc; m_hist[k] = m_acc; m_acc = 0; m_nvalid = k + 1;
                m_best_err = CMAX; m_best_set = 0;
                for (int i = 0; i < m_nvalid; i++)
                    if (m_errs[i] < m_best_err) begin m_best_err = m_errs[i]; m_best_set = i; end
                if (k < 7) m_idx = k + 1;
            end
            m_pos++;
        end else if (m_pos < LOCK0) begin
            m_idx = m_best_set;
            m_pos = (m_best_err > LME) ? 0 : m_pos + 1;
        end else begin
            m_acc = sat(m_acc + int'(phase_err));
            if ((m_pos - LOCK0) % D == D - 1) begin
                if (m_acc > LT) begin
                    m_relock = m_relock < 255 ? m_relock + 1 : 255;
                    m_pos = 0;
                end else m_pos++;
                m_acc = 0;
            end else m_pos++;
        end
        m_exp_scanning = m_mode == 1 && m_pos <= 8 * L;
        m_exp_locked   = m_mode == 1 && m_pos >= LOCK0;
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            check("phase_sel", phase_sel, m_idx % 4);
            check("polswap", polswap, m_idx / 4);
            check("locked", locked, m_exp_locked);
            check("scanning", scanning, m_exp_scanning);
            check("best_setting", best_setting, m_best_set);
            check("best_errcnt", best_errcnt, m_best_err);
            check("relock_cnt", relock_cnt, m_relock);
`ifdef SOF_PHASE_SCANNER_HISTORY_EN
            for (int i = 0; i < 8; i++) check("err_hist", err_hist[i*CW +: CW], m_hist[i]);
`endif
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic bit in_meas();
        return m_mode == 1 && m_pos >= 1 && m_pos <= 8 * L && (m_pos - 1) % L >= S;
    endfunction

    function automatic bit in_flush();
        return m_mode == 1 && ((m_pos >= 1 && m_pos <= 8 * L && (m_pos - 1) % L < S) ||
                               (m_pos >= APPLY0 && m_pos < LOCK0));
    endfunction

    function automatic int cur_k();
        return (m_pos - 1) / L;
    endfunction

    function automatic int wpos();
        return (m_pos - 1) % L - S;
    endfunction

    function automatic bit gen_pe();
        if (in_flush()) return 1'($urandom % 2);
        if (in_meas()) begin
            case (pe_mode)
                1: return cur_k() != 5;
                2: return (cur_k() == 2 || cur_k() == 6) ? wpos() < 3 : 1'b1;
                3: return wpos() < 10 || ($urandom % 2) == 1;
                default: return 1'b0;
            endcase
        end
        if (m_mode == 1 && m_pos >= LOCK0 && pe_mode == 4) return (m_pos - LOCK0) % D < inj;
        return 1'b0;
    endfunction

    task automatic tick();
        @(negedge clock);
        phase_err = gen_pe();
    endtask

    initial begin
        int n;
        int seen;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_locked", locked, 0);
        check("rst_scanning", scanning, 0);
        check("rst_phase_sel", phase_sel, 0);
        check("rst_best_errcnt", best_errcnt, 0);
        check("rst_relock", relock_cnt, 0);

        // A: only setting 5 is clean; lock timing pinned by hand.
        reset = 1'b0; enable = 1'b1; pe_mode = 1; phase_err = gen_pe();
        repeat (8266) tick();
        check("A_lock_early", locked, 0);
        tick();
        check("A_lock_time", locked, 1);
        check("A_best_setting", best_setting, 5);
        check("A_best_errcnt", best_errcnt, 0);
        check("A_phase_sel", phase_sel, 1);
        check("A_polswap", polswap, 1);
        check("A_scanning", scanning, 0);

        // 16 errors per window keep the lock.
        pe_mode = 4; inj = 16;
        repeat (2 * D) tick();
        check("A16_held", locked, 1);

        // B: rescan while locked; settings 2 and 6 tie at 3 errors.
        pe_mode = 2; rescan = 1'b1; tick(); rescan = 1'b0;
        check("B_rescan_scanning", scanning, 1);
        n = 0;
        while (!m_exp_locked && n < 9000) begin tick(); n++; end
        check("B_reached_lock", m_exp_locked, 1);
        check("B_locked", locked, 1);
        check("B_best_setting", best_setting, 2);
        check("B_best_errcnt", best_errcnt, 3);
        check("B_phase_sel", phase_sel, 2);
        check("B_polswap", polswap, 0);
        check("B_relock", relock_cnt, 0);
`ifdef SOF_PHASE_SCANNER_HISTORY_EN
        check("B_hist2", err_hist[2*CW +: CW], 3);
        check("B_hist6", err_hist[6*CW +: CW], 3);
        check("B_hist5", err_hist[5*CW +: CW], 1024);
`endif

        // D: 17 errors in a window lose lock.
        pe_mode = 4; inj = 17;
        n = 0;
        while (m_exp_locked && n < 3 * D) begin tick(); n++; end
        check("D_reached_loss", m_exp_locked, 0);
        check("D_locked", locked, 0);
        check("D_relock", relock_cnt, 1);
        check("D_scanning", scanning, 1);

        // C: every setting has >=10 errors, so no lock and an automatic rescan.
        pe_mode = 3; seen = 0; n = 0;
        while (!(m_mode == 1 && m_pos > 8 * L) && n < 9000) begin tick(); n++; if (locked) seen++; end
        n = 0;
        while (m_pos != 0 && n < 20) begin tick(); n++; if (locked) seen++; end
        check("C_restart", m_pos, 0);
        check("C_never_locked", seen, 0);
        check("C_scanning", scanning, 1);
        check("C_best_ge10", best_errcnt >= 10, 1);
        tick();
        check("C_best_cleared", best_errcnt, CMAX);
        check("C_idx0", phase_sel, 0);

        // E: rescan mid-MEASURE at setting 3, relock, then disable.
        pe_mode = 0; n = 0;
        while (!(in_meas() && cur_k() == 3 && wpos() == 100) && n < 5000) begin tick(); n++; end
        check("E_reached_idx3", cur_k(), 3);
        rescan = 1'b1; tick(); rescan = 1'b0;
        check("E_scanning", scanning, 1);
        tick();
        check("E_best_cleared", best_errcnt, CMAX);
        check("E_best_set0", best_setting, 0);
        check("E_idx0", phase_sel, 0);
        check("E_relock", relock_cnt, 1);
        n = 0;
        while (!m_exp_locked && n < 9000) begin tick(); n++; end
        check("E_locked", locked, 1);
        check("E_best_errcnt", best_errcnt, 0);
        enable = 1'b0; tick();
        check("E_idle_locked", locked, 0);
        check("E_idle_scanning", scanning, 0);
        check("E_idle_relock", relock_cnt, 1);

        // F: reset during MEASURE at setting 4.
        enable = 1'b1; pe_mode = 3; n = 0;
        while (!(in_meas() && cur_k() == 4) && n < 6000) begin tick(); n++; end
        check("F_reached_idx4", cur_k(), 4);
        reset = 1'b1; tick();
        check("F_locked", locked, 0);
        check("F_scanning", scanning, 0);
        check("F_phase_sel", phase_sel, 0);
        check("F_best_setting", best_setting, 0);
        check("F_best_errcnt", best_errcnt, 0);
        check("F_relock", relock_cnt, 0);
`ifdef SOF_PHASE_SCANNER_HISTORY_EN
        check("F_hist", err_hist, 0);
`endif
        reset = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
